// File: rtl/ssg_display_ctrl.sv
// Four-digit seven-segment display sequencer.
// Accepts a hi/lo value pair over valid/ready. Each value is converted to two
// BCD digits by a serial double-dabble engine. All four digits are then
// committed together, and the anodes are time-multiplexed with a blanking
// gap at the start of every digit slot.
module ssg_display_ctrl #(
  parameter int WIDTH        = 8,
  parameter int REFRESH_BITS = 18,
  parameter int BLANK_CYCLES = 64,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic             clock_50Mhz,
  input  logic             reset,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [WIDTH-1:0] value_hi,
  input  logic [WIDTH-1:0] value_lo,
  output logic [3:0]       anode_activate,
  output logic [6:0]       led_out,
  output logic             ovf_hi,
  output logic             ovf_lo
);

  typedef enum logic [1:0] {IDLE, CONV_HI, CONV_LO, COMMIT} state_t;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  state_t      state, state_nxt;
  logic [2:0]  iter;
  logic [6:0]  bin_sr;
  logic [7:0]  bcd_sr;
  logic [7:0]  bcd_adj;
  logic [7:0]  bcd_next;
  logic [7:0]  hi_bcd;
  logic [6:0]  lo_bin;
  logic        pend_ovf_hi, pend_ovf_lo;
  logic [3:0]  dig3, dig2, dig1, dig0;
  logic        last_iter;

  logic [REFRESH_BITS+1:0] scan_cnt;
  logic [1:0]              slot;
  logic                    blank;
  logic [3:0]              sel_digit;
  logic                    sel_ovf;
  logic                    sel_tens;
  logic [3:0]              anode_nxt;
  logic [6:0]              led_nxt;

  // Active-low segment pattern for one decimal digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = SEG_OFF;
    endcase
  endfunction

  assign upd_ready = (state == IDLE);
  assign last_iter = (iter == 3'd6);

  // One double-dabble iteration: add 3 to each nibble >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj[7:4] = (bcd_sr[7:4] >= 4'd5) ? bcd_sr[7:4] + 4'd3 : bcd_sr[7:4];
    bcd_adj[3:0] = (bcd_sr[3:0] >= 4'd5) ? bcd_sr[3:0] + 4'd3 : bcd_sr[3:0];
    bcd_next     = {bcd_adj[6:0], bin_sr[6]};
  end

  // State register.
  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: seven iterations per field, then a single commit cycle.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (upd_valid) state_nxt = CONV_HI;
      CONV_HI: if (last_iter) state_nxt = CONV_LO;
      CONV_LO: if (last_iter) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion datapath and atomic commit of all four digits plus overflow flags.
  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      iter        <= '0;
      bin_sr      <= '0;
      bcd_sr      <= '0;
      hi_bcd      <= '0;
      lo_bin      <= '0;
      pend_ovf_hi <= 1'b0;
      pend_ovf_lo <= 1'b0;
      dig3        <= '0;
      dig2        <= '0;
      dig1        <= '0;
      dig0        <= '0;
      ovf_hi      <= 1'b0;
      ovf_lo      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (upd_valid) begin
          bin_sr      <= value_hi[6:0];
          lo_bin      <= value_lo[6:0];
          bcd_sr      <= '0;
          iter        <= '0;
          pend_ovf_hi <= (value_hi > WIDTH'(99));
          pend_ovf_lo <= (value_lo > WIDTH'(99));
        end
        CONV_HI: begin
          if (last_iter) begin
            hi_bcd <= bcd_next;
            bcd_sr <= '0;
            bin_sr <= lo_bin;
            iter   <= '0;
          end else begin
            bcd_sr <= bcd_next;
            bin_sr <= {bin_sr[5:0], 1'b0};
            iter   <= iter + 3'd1;
          end
        end
        CONV_LO: begin
          bcd_sr <= bcd_next;
          bin_sr <= {bin_sr[5:0], 1'b0};
          iter   <= last_iter ? 3'd0 : iter + 3'd1;
        end
        COMMIT: begin
          dig3   <= hi_bcd[7:4];
          dig2   <= hi_bcd[3:0];
          dig1   <= bcd_sr[7:4];
          dig0   <= bcd_sr[3:0];
          ovf_hi <= pend_ovf_hi;
          ovf_lo <= pend_ovf_lo;
        end
        default: ;
      endcase
    end
  end

  // Free-running scan counter; its wrap is intentional.
  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) scan_cnt <= '0;
    else       scan_cnt <= scan_cnt + 1'b1;
  end

  // Choose the digit for the current slot and form its anode/cathode pattern.
  always_comb begin
    slot      = scan_cnt[REFRESH_BITS+1:REFRESH_BITS];
    blank     = (int'(scan_cnt[REFRESH_BITS-1:0]) < BLANK_CYCLES);
    anode_nxt = 4'b1111;
    sel_digit = dig3;
    sel_ovf   = ovf_hi;
    sel_tens  = 1'b1;
    case (slot)
      2'd0: begin anode_nxt = 4'b0111; sel_digit = dig3; sel_ovf = ovf_hi; sel_tens = 1'b1; end
      2'd1: begin anode_nxt = 4'b1011; sel_digit = dig2; sel_ovf = ovf_hi; sel_tens = 1'b0; end
      2'd2: begin anode_nxt = 4'b1101; sel_digit = dig1; sel_ovf = ovf_lo; sel_tens = 1'b1; end
      default: begin anode_nxt = 4'b1110; sel_digit = dig0; sel_ovf = ovf_lo; sel_tens = 1'b0; end
    endcase
    if (sel_ovf)
      led_nxt = SEG_DASH;
    else if ((LZ_SUPPRESS != 0) && sel_tens && (sel_digit == 4'd0))
      led_nxt = SEG_OFF;
    else
      led_nxt = seg_decode(sel_digit);
    if (blank) begin
      anode_nxt = 4'b1111;
      led_nxt   = SEG_OFF;
    end
  end

  // Registered display outputs, one cycle behind the scan counter.
  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      anode_activate <= 4'b1111;
      led_out        <= SEG_OFF;
    end else begin
      anode_activate <= anode_nxt;
      led_out        <= led_nxt;
    end
  end

endmodule

// File: tb/tb_ssg_display_ctrl.sv
// Self-checking bench for ssg_display_ctrl with a small scan period.
// The reference model tracks the accepted and displayed value pairs as integers.
// Expected outputs are derived from decimal arithmetic on those values and from
// the count of clock edges since reset.
module tb_ssg_display_ctrl;
  localparam int WIDTH = 8;
  localparam int RB    = 4;
  localparam int BC    = 2;
  localparam int SCAN_MOD = 1 << (RB + 2);

  localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000, 7'b0000100};

  logic             clock_50Mhz = 1'b0;
  logic             reset = 1'b1;
  logic             upd_valid = 1'b0;
  logic             upd_ready;
  logic [WIDTH-1:0] value_hi = '0;
  logic [WIDTH-1:0] value_lo = '0;
  logic [3:0]       anode_activate;
  logic [6:0]       led_out;
  logic             ovf_hi, ovf_lo;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  int   edge_n = 0;
  bit   m_idle = 1'b1;
  int   m_accept = 0;
  int   n_accepted = 0;
  int   pend_hi = 0, pend_lo = 0;
  int   disp_hi = 0, disp_lo = 0;
  logic [3:0] exp_anode = 4'b1111;
  logic [6:0] exp_led = 7'b1111111;
  logic exp_ovf_hi = 1'b0, exp_ovf_lo = 1'b0;

  ssg_display_ctrl #(
    .WIDTH(WIDTH), .REFRESH_BITS(RB), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1)
  ) dut (
    .clock_50Mhz(clock_50Mhz), .reset(reset),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .value_hi(value_hi), .value_lo(value_lo),
    .anode_activate(anode_activate), .led_out(led_out),
    .ovf_hi(ovf_hi), .ovf_lo(ovf_lo)
  );

  always #10 clock_50Mhz = ~clock_50Mhz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Expected {anode, led} for scan position cnt with the given displayed values.
  function automatic logic [10:0] model_out(input int cnt, input int hi, input int lo);
    int slot, low, v, d;
    logic [3:0] an;
    logic [6:0] led;
    slot = (cnt >> RB) % 4;
    low  = cnt % (1 << RB);
    if (low < BC) return {4'b1111, 7'b1111111};
    v  = (slot < 2) ? hi : lo;
    d  = (slot % 2 == 0) ? v / 10 : v % 10;
    an = 4'b1000 >> slot;
    an = ~an;
    if (v > 99)                       led = 7'b1111110;
    else if (slot % 2 == 0 && d == 0) led = 7'b1111111;
    else                              led = SEG[d];
    return {an, led};
  endfunction

  // Advance one clock edge and update the model; returns #1 after the edge.
  task automatic step();
    @(posedge clock_50Mhz);
    {exp_anode, exp_led} = model_out(edge_n % SCAN_MOD, disp_hi, disp_lo);
    edge_n++;
    if (m_idle) begin
      if (upd_valid) begin
        m_idle   = 1'b0;
        m_accept = edge_n;
        pend_hi  = int'(value_hi);
        pend_lo  = int'(value_lo);
        n_accepted++;
      end
    end else if (edge_n == m_accept + 15) begin
      m_idle  = 1'b1;
      disp_hi = pend_hi;
      disp_lo = pend_lo;
    end
    exp_ovf_hi = (disp_hi > 99);
    exp_ovf_lo = (disp_lo > 99);
    #1;
  endtask

  task automatic model_reset();
    edge_n = 0; m_idle = 1'b1; disp_hi = 0; disp_lo = 0;
    exp_anode = 4'b1111; exp_led = 7'b1111111;
    exp_ovf_hi = 1'b0; exp_ovf_lo = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock_50Mhz);
    #1;
    model_reset();
    tests_run++;
    if ({anode_activate, led_out} !== {exp_anode, exp_led}) begin
      tests_failed++;
      $display("FAIL reset_seg: got %b/%b required %b/%b", anode_activate, led_out, exp_anode, exp_led);
    end
    tests_run++;
    if ({upd_ready, ovf_hi, ovf_lo} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_ctl: got rdy/ovf %b%b%b required 100", upd_ready, ovf_hi, ovf_lo);
    end
    reset = 1'b0;
    for (int i = 0; i < SCAN_MOD + 4; i++) begin
      step();
      tests_run++;
      if ({anode_activate, led_out} !== {exp_anode, exp_led}) begin
        tests_failed++;
        $display("FAIL idle_scan cyc=%0d: got %b/%b required %b/%b", edge_n, anode_activate, led_out, exp_anode, exp_led);
      end
      tests_run++;
      if ({upd_ready, ovf_hi, ovf_lo} !== {m_idle, exp_ovf_hi, exp_ovf_lo}) begin
        tests_failed++;
        $display("FAIL idle_ctl cyc=%0d: got %b%b%b required %b%b%b", edge_n, upd_ready, ovf_hi, ovf_lo, m_idle, exp_ovf_hi, exp_ovf_lo);
      end
    end
  endtask

  // Offers one pair, then watches conversion, commit and a full scan.
  task automatic test_update(input string name, input int hv, input int lv, input int tail);
    upd_valid = 1'b1;
    value_hi  = WIDTH'(hv);
    value_lo  = WIDTH'(lv);
    for (int i = 0; i < 16 + tail; i++) begin
      step();
      if (!m_idle) upd_valid = 1'b0;
      tests_run++;
      if ({anode_activate, led_out} !== {exp_anode, exp_led}) begin
        tests_failed++;
        $display("FAIL %s_seg cyc=%0d: got %b/%b required %b/%b", name, edge_n, anode_activate, led_out, exp_anode, exp_led);
      end
      tests_run++;
      if ({upd_ready, ovf_hi, ovf_lo} !== {m_idle, exp_ovf_hi, exp_ovf_lo}) begin
        tests_failed++;
        $display("FAIL %s_ctl cyc=%0d: got %b%b%b required %b%b%b", name, edge_n, upd_ready, ovf_hi, ovf_lo, m_idle, exp_ovf_hi, exp_ovf_lo);
      end
    end
  endtask

  task automatic test_ignore();
    upd_valid = 1'b1; value_hi = 8'd23; value_lo = 8'd58;
    for (int i = 0; i < 16 + SCAN_MOD; i++) begin
      step();
      upd_valid = 1'b0;
      if (edge_n == m_accept + 9 && !m_idle) begin
        upd_valid = 1'b1; value_hi = 8'd11; value_lo = 8'd11;
      end
      tests_run++;
      if ({anode_activate, led_out} !== {exp_anode, exp_led}) begin
        tests_failed++;
        $display("FAIL ignore_seg cyc=%0d: got %b/%b required %b/%b", edge_n, anode_activate, led_out, exp_anode, exp_led);
      end
      tests_run++;
      if ({upd_ready, ovf_hi, ovf_lo} !== {m_idle, exp_ovf_hi, exp_ovf_lo}) begin
        tests_failed++;
        $display("FAIL ignore_ctl cyc=%0d: got %b%b%b required %b%b%b", edge_n, upd_ready, ovf_hi, ovf_lo, m_idle, exp_ovf_hi, exp_ovf_lo);
      end
    end
  endtask

  task automatic test_reset_mid();
    upd_valid = 1'b1; value_hi = 8'd55; value_lo = 8'd66;
    step();
    upd_valid = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if ({anode_activate, led_out, upd_ready, ovf_hi, ovf_lo} !== {4'b1111, 7'b1111111, 3'b100}) begin
      tests_failed++;
      $display("FAIL midreset_async: got %b/%b rdy/ovf %b%b%b required 1111/1111111 100", anode_activate, led_out, upd_ready, ovf_hi, ovf_lo);
    end
    repeat (2) @(posedge clock_50Mhz);
    #1;
    reset = 1'b0;
    for (int i = 0; i < SCAN_MOD + 8; i++) begin
      step();
      tests_run++;
      if ({anode_activate, led_out} !== {exp_anode, exp_led}) begin
        tests_failed++;
        $display("FAIL midreset_seg cyc=%0d: got %b/%b required %b/%b", edge_n, anode_activate, led_out, exp_anode, exp_led);
      end
      tests_run++;
      if ({upd_ready, ovf_hi, ovf_lo} !== {m_idle, exp_ovf_hi, exp_ovf_lo}) begin
        tests_failed++;
        $display("FAIL midreset_ctl cyc=%0d: got %b%b%b required %b%b%b", edge_n, upd_ready, ovf_hi, ovf_lo, m_idle, exp_ovf_hi, exp_ovf_lo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_accepted;
    upd_valid = 1'b1; value_hi = 8'd12; value_lo = 8'd34;
    for (int i = 0; i < 32 + SCAN_MOD; i++) begin
      step();
      if (n_accepted == base + 1) begin value_hi = 8'd56; value_lo = 8'd78; end
      if (n_accepted == base + 2) upd_valid = 1'b0;
      tests_run++;
      if ({anode_activate, led_out} !== {exp_anode, exp_led}) begin
        tests_failed++;
        $display("FAIL b2b_seg cyc=%0d: got %b/%b required %b/%b", edge_n, anode_activate, led_out, exp_anode, exp_led);
      end
      tests_run++;
      if ({upd_ready, ovf_hi, ovf_lo} !== {m_idle, exp_ovf_hi, exp_ovf_lo}) begin
        tests_failed++;
        $display("FAIL b2b_ctl cyc=%0d: got %b%b%b required %b%b%b", edge_n, upd_ready, ovf_hi, ovf_lo, m_idle, exp_ovf_hi, exp_ovf_lo);
      end
    end
    tests_run++;
    if (n_accepted !== base + 2) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d accepted required %0d", n_accepted - base, 2);
    end
  endtask

  task automatic test_random();
    int hv, lv;
    for (int k = 0; k < 8; k++) begin
      hv = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(100, 255));
      lv = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(100, 255));
      repeat ($urandom_range(0, 3)) step();
      test_update("rand", hv, lv, int'($urandom_range(4, SCAN_MOD + 4)));
    end
  endtask

  initial begin
    test_reset();
    test_update("basic", 42, 7, SCAN_MOD);
    test_update("ovf", 150, 99, SCAN_MOD);
    test_update("zeros", 0, 90, SCAN_MOD);
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
